// File: rtl/index_buff_reader.sv
// index_buff_reader: streams the 16-row sparse-index buffer back out in row-major order over valid/ready.
// Define INDEX_START_ROW_EN to add a start_row input so a pass can begin at a row other than 0.
module index_buff_reader #(
    parameter int Ram_Row         = 16,
    parameter int Read_Addr_Width = 11,
    parameter int Read_Data_Width = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [Read_Addr_Width+4:0]           Addr_end,
`ifdef INDEX_START_ROW_EN
    input  logic [3:0]                           start_row,
`endif
    output logic [Read_Addr_Width*Ram_Row-1:0]   addrin_row,
    output logic [Ram_Row-1:0]                   enb_row,
    input  logic [Read_Data_Width*Ram_Row-1:0]   datain_row,
    output logic [Read_Data_Width-1:0]           dataout,
    output logic                                 dout_valid,
    input  logic                                 dout_ready,
    output logic                                 busy,
    output logic                                 finished
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [Read_Addr_Width-1:0] ColOne = {{(Read_Addr_Width-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_stateNext;
    logic [Read_Addr_Width-1:0]  r_numWords;
    logic [Read_Addr_Width-1:0]  r_col;
    logic [3:0]                  r_row;
    logic                        r_inflight;
    logic [3:0]                  r_inflightRow;
    logic [Read_Data_Width-1:0]  r_head;
    logic [Read_Data_Width-1:0]  r_tail;
    logic [1:0]                  r_count;

    logic [Read_Addr_Width-1:0]  w_addrN;
    logic [Read_Addr_Width-1:0]  w_colLast;
    logic [3:0]                  w_firstRow;
    logic [2:0]                  w_credit;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_issue;
    logic                        w_lastIssue;
    logic [Read_Data_Width-1:0]  w_readWord;
    logic                        w_unusedAddrBits;

    // Low nibble is the per-row remainder and is dropped; the top bit falls outside the N width.
    assign w_addrN          = Addr_end[Read_Addr_Width+3:4];
    assign w_unusedAddrBits = ^{Addr_end[3:0], Addr_end[Read_Addr_Width+4]};
    assign w_colLast        = r_numWords - ColOne;

`ifdef INDEX_START_ROW_EN
    assign w_firstRow = start_row;
`else
    assign w_firstRow = 4'd0;
`endif

    // Credit counts stored plus in-flight words, net of this cycle's pop, so the 2-entry FIFO never overflows.
    assign w_pop       = (r_count != 2'd0) && dout_ready;
    assign w_push      = r_inflight;
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == READ) && (w_credit < 3'd2);
    assign w_lastIssue = w_issue && (r_row == 4'd15) && (r_col == w_colLast);
    assign w_readWord  = datain_row[r_inflightRow*Read_Data_Width +: Read_Data_Width];

    assign dout_valid = (r_count != 2'd0);
    assign dataout    = r_head;
    assign busy       = (r_state == READ) || (r_state == DRAIN);
    assign finished   = (r_state == DONE);

    always_comb begin
        enb_row    = '0;
        addrin_row = '0;
        if (w_issue) begin
            enb_row[r_row] = 1'b1;
            addrin_row[r_row*Read_Addr_Width +: Read_Addr_Width] = r_col;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = (w_addrN == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_lastIssue) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last word is popped so finished lands the cycle after that handshake.
                if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_numWords <= '0;
            r_col      <= '0;
            r_row      <= 4'd0;
        end else if ((r_state == IDLE) && start) begin
            r_numWords <= w_addrN;
            r_col      <= '0;
            r_row      <= w_firstRow;
        end else if (w_issue) begin
            if (r_col == w_colLast) begin
                r_col <= '0;
                r_row <= r_row + 4'd1;
            end else begin
                r_col <= r_col + ColOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_inflightRow <= 4'd0;
        end else begin
            r_inflight    <= w_issue;
            r_inflightRow <= r_row;
        end
    end

    // Head/tail FIFO: the head register doubles as dataout and keeps its value once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_readWord;
                    end else begin
                        r_tail <= w_readWord;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= w_readWord;
                    end else begin
                        r_head <= w_readWord;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_buff_reader.sv
// tb_index_buff_reader: randomized passes checked against a queue-based model of the expected read order.
// Build with INDEX_START_ROW_EN defined to also exercise the start_row window.
module tb_index_buff_reader;

    localparam int RW = 16;
    localparam int AW = 11;
    localparam int DW = 64;

    logic               clk;
    logic               rst;
    logic               start;
    logic [AW+4:0]      Addr_end;
`ifdef INDEX_START_ROW_EN
    logic [3:0]         start_row;
`endif
    logic [AW*RW-1:0]   addrin_row;
    logic [RW-1:0]      enb_row;
    logic [DW*RW-1:0]   datain_row;
    logic [DW-1:0]      dataout;
    logic               dout_valid;
    logic               dout_ready;
    logic               busy;
    logic               finished;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    logic [63:0] expQ[$];
    logic [14:0] expIssue[$];
    logic [31:0] salt = 32'h0;
    int  total, issued, popped, acceptCycle, lastPopCycle, lastIssueRow, readyMode;
    bit  mon = 0;
    bit  passOpen = 0;
    bit  firstSeen, heldValid;
    logic [63:0] heldData;

    index_buff_reader #(
        .Ram_Row(RW),
        .Read_Addr_Width(AW),
        .Read_Data_Width(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .Addr_end(Addr_end),
`ifdef INDEX_START_ROW_EN
        .start_row(start_row),
`endif
        .addrin_row(addrin_row),
        .enb_row(enb_row),
        .datain_row(datain_row),
        .dataout(dataout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy(busy),
        .finished(finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Row RAMs with 1-cycle latency; row r address a holds {salt, r, a}.
    initial datain_row = '0;
    always @(posedge clk) begin
        for (int r = 0; r < RW; r++) begin
            if (enb_row[r]) begin
                datain_row[r*DW +: DW] <= {salt, 16'(r), 5'd0, addrin_row[r*AW +: AW]};
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".finished"}, 64'(finished), 64'd0);
        checkOutput({tag, ".dout_valid"}, 64'(dout_valid), 64'd0);
        checkOutput({tag, ".dataout"}, dataout, 64'd0);
        checkOutput({tag, ".enb_row"}, 64'(enb_row), 64'd0);
        checkOutput({tag, ".addrZero"}, 64'(addrin_row == '0), 64'd1);
    endtask

    always @(negedge clk) begin
        if (mon) begin
            logic [AW*RW-1:0] mask;
            logic [14:0]      e;
            logic [63:0]      w;
            int               r;
            bit               expF;
            if (enb_row != '0) begin
                checkOutput("enbOneHot", 64'($countones(enb_row)), 64'd1);
                r = 0;
                for (int i = 0; i < RW; i++) if (enb_row[i]) r = i;
                lastIssueRow = r;
                if (expIssue.size() == 0) begin
                    checkOutput("issueExtra", 64'(enb_row), 64'd0);
                end else begin
                    e = expIssue.pop_front();
                    checkOutput("issueRow", 64'(r), 64'(e[14:11]));
                    checkOutput("issueAddr", 64'(addrin_row[r*AW +: AW]), 64'(e[10:0]));
                end
                mask = '0;
                mask[r*AW +: AW] = '1;
                checkOutput("addrOtherZero", 64'((addrin_row & ~mask) == '0), 64'd1);
                issued++;
            end else begin
                checkOutput("addrIdle", 64'(addrin_row == '0), 64'd1);
            end
            if (heldValid) begin
                checkOutput("validHold", 64'(dout_valid), 64'd1);
                checkOutput("dataStable", dataout, heldData);
            end
            if (!firstSeen && dout_valid) begin
                firstSeen = 1;
                checkOutput("firstLatency", 64'(cycle - acceptCycle), 64'd2);
            end else if (readyMode == 0 && firstSeen && popped < total) begin
                checkOutput("noBubble", 64'(dout_valid), 64'd1);
            end
            if (dout_valid && dout_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("popExtra", 64'd1, 64'd0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("dataout", dataout, w);
                end
                popped++;
                if (popped == total) lastPopCycle = cycle;
            end
            checkOutput("creditBound", 64'((issued - popped) <= 2), 64'd1);
            heldValid = dout_valid && !dout_ready;
            heldData  = dataout;
            expF = (cycle == lastPopCycle + 1);
            checkOutput("finished", 64'(finished), 64'(expF));
            checkOutput("busy", 64'(busy), 64'(passOpen && (cycle >= acceptCycle) && !expF));
            if (expF) passOpen = 0;
        end
    end

    task automatic beginPass(input int addrEnd, input int sRow, input int mode);
        int n;
        int firstRow;
`ifdef INDEX_START_ROW_EN
        firstRow = sRow;
`else
        firstRow = 0;
`endif
        n = (addrEnd >> 4) & 'h7FF;
        expQ.delete();
        expIssue.delete();
        salt = $urandom;
        for (int r = firstRow; r < RW; r++) begin
            for (int a = 0; a < n; a++) begin
                expQ.push_back({salt, 16'(r), 16'(a)});
                expIssue.push_back({4'(r), 11'(a)});
            end
        end
        total        = expQ.size();
        issued       = 0;
        popped       = 0;
        firstSeen    = 0;
        heldValid    = 0;
        lastIssueRow = -1;
        readyMode    = mode;
        acceptCycle  = cycle + 1;
        lastPopCycle = (total == 0) ? acceptCycle - 1 : -10;
        Addr_end     = 16'(addrEnd);
`ifdef INDEX_START_ROW_EN
        start_row    = 4'(sRow);
`endif
        dout_ready   = 1'b1;
        start        = 1'b1;
        passOpen     = 1;
        mon          = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int addrEnd, input int sRow, input int mode, input bit midStart);
        beginPass(addrEnd, sRow, mode);
        for (int k = 0; k < 3000 && passOpen; k++) begin
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (k % 2 == 0);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (midStart && k == 10) begin
                start    = 1'b1;
                Addr_end = 16'($urandom_range(16, 255));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("passTimeout", 64'(passOpen), 64'd0);
        checkOutput("wordCount", 64'(popped), 64'(total));
        repeat (3) begin
            start = 1'b0;
            @(posedge clk);
            #1;
        end
        mon = 0;
    endtask

    task automatic resetMidPass();
        beginPass(64, 0, 2);
        for (int k = 0; k < 500 && lastIssueRow != 7; k++) begin
            dout_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("reachRow7", 64'(lastIssueRow), 64'd7);
        dout_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        mon = 0;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midReset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        passOpen = 0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b0;
        Addr_end   = '0;
`ifdef INDEX_START_ROW_EN
        start_row  = 4'd0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(64, 0, 0, 0);
        applyStimulus(64, 0, 1, 0);
        applyStimulus(15, 0, 0, 0);
        resetMidPass();
        applyStimulus(32, 0, 0, 0);
        applyStimulus(64, 0, 2, 1);
`ifdef INDEX_START_ROW_EN
        applyStimulus(32, 13, 0, 0);
`endif
        for (int p = 0; p < 4; p++) begin
            applyStimulus($urandom_range(0, 90), $urandom_range(0, 15), $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
